rd_arbiter: RTL



---
 rtl/rd_arbiter_if.sv | 28 ++
 rtl/rd_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rd_arbiter_if.sv
// Read-side bus of the FIFO arbiter: synchronized write pointer and requests in,
// grants, pop strobes, read address, Gray read pointer and status flags out.
interface rd_arbiter_if #(
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rvalid;
  logic                rinc;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [ADDRSIZE:0]   rlevel;

  // Arbiter side
  modport master (
    input  rq2_wptr, req,
    output gnt, rvalid, rinc, raddr, rptr, rempty, rlevel
  );

  // Requester / FIFO side
  modport slave (
    output rq2_wptr, req,
    input  gnt, rvalid, rinc, raddr, rptr, rempty, rlevel
  );
endinterface

// File: rtl/rd_arbiter.sv
// Round-robin read arbiter for an async FIFO read port. Grants one requester at a
// time for a burst of up to MAXBURST pops, owns the binary/Gray read pointer and
// derives the empty flag and fill level from the synchronized write pointer.
module rd_arbiter #(
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic          rclk,
  input  logic          rrst_n,
  rd_arbiter_if.master  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     r_last;
  logic [CW-1:0]     r_cnt;
  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic [ADDRSIZE:0] r_rlevel;
  logic              r_rempty;

  logic              w_rinc;
  logic [ADDRSIZE:0] w_rbin_next;
  logic [ADDRSIZE:0] w_rgray_next;
  logic [ADDRSIZE:0] w_wbin;
  logic [IW-1:0]     w_sel;
  logic              w_found;
  logic              w_burst_end;

  // Gray-to-binary of the write pointer: each binary bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
      assign w_wbin[gi] = ^bus.rq2_wptr[ADDRSIZE:gi];
    end
  endgenerate

  // Pop only while a burst is active, the owner still requests and data is present
  assign w_rinc        = (r_state == S_BURST) && bus.req[r_gidx] && !r_rempty;
  assign w_rbin_next   = r_rbin + {{ADDRSIZE{1'b0}}, w_rinc};
  assign w_rgray_next  = w_rbin_next ^ (w_rbin_next >> 1);
  assign w_burst_end   = !bus.req[r_gidx] || r_rempty ||
                         (w_rinc && (r_cnt == CW'(MAXBURST - 1)));

  // Round-robin pick: first active request scanning upward from the last owner + 1
  always_comb begin
    int v_idx;
    w_sel   = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = (int'(r_last) + k) % NREQ;
      if (!w_found && bus.req[IW'(v_idx)]) begin
        w_found = 1'b1;
        w_sel   = IW'(v_idx);
      end
    end
  end

  // Read pointer, Gray pointer, empty flag and fill level all track rbin_next
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
      r_rlevel <= '0;
    end else begin
      r_rbin   <= w_rbin_next;
      r_rptr   <= w_rgray_next;
      r_rempty <= (w_rgray_next == bus.rq2_wptr);
      r_rlevel <= w_wbin - w_rbin_next;
    end
  end

  // Grant FSM: IDLE picks a requester, BURST pops until drop, empty or burst limit
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !r_rempty) begin
            r_state <= S_BURST;
            r_gnt   <= NREQ'(1) << w_sel;
            r_gidx  <= w_sel;
            r_cnt   <= '0;
          end
        end
        S_BURST: begin
          if (w_burst_end) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= r_gidx;
            r_cnt   <= '0;
          end else if (w_rinc) begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.rvalid = r_gnt & {NREQ{w_rinc}};
  assign bus.rinc   = w_rinc;
  assign bus.raddr  = r_rbin[ADDRSIZE-1:0];
  assign bus.rptr   = r_rptr;
  assign bus.rempty = r_rempty;
  assign bus.rlevel = r_rlevel;

endmodule
